// File: rtl/meteor_if.sv
// meteor_if: bus between the meteor controller and the ball collision logic.
//   ball_die      : collision pulse from the ball block, sampled on frame_clk
//   enemy_x/y     : meteor left/top edge in pixels
//   enemy_size    : meteor side length in pixels (0 while parked)
//   meteor_active : high while a meteor is falling
//   speed         : current fall speed in pixels per frame
//   dodged_count  : meteors that left the bottom of the screen
//   fall_state    : FSM state for debug (0 = WAIT, 1 = FALL)
// Signalling: there is no valid/ready pair. ball_die is a single-frame level
// sampled at each rising edge of frame_clk; every other signal is a registered
// level that is valid for the whole frame following the edge that produced it.
interface meteor_if;
    logic       ball_die;
    logic [9:0] enemy_x;
    logic [9:0] enemy_y;
    logic [9:0] enemy_size;
    logic       meteor_active;
    logic [2:0] speed;
    logic [15:0] dodged_count;
    logic       fall_state;

    modport master (
        input  ball_die,
        output enemy_x, enemy_y, enemy_size, meteor_active, speed,
               dodged_count, fall_state
    );

    modport slave (
        output ball_die,
        input  enemy_x, enemy_y, enemy_size, meteor_active, speed,
               dodged_count, fall_state
    );
endinterface

// File: rtl/meteor_ctrl.sv
// meteor_ctrl: single-meteor obstacle generator.
// Waits SPAWN_DELAY frames, spawns a meteor at an LFSR-chosen column and size,
// drops it by `speed` pixels per frame, and parks it again when it leaves the
// bottom (a dodge) or when the ball reports a collision.
// Ports:
//   frame_clk : frame clock, the only clock
//   Reset     : synchronous, active-high
//   bus       : meteor_if master (ball_die in; position, size, status out)
module meteor_ctrl #(
    parameter int          X_MIN       = 3,
    parameter int          X_MAX       = 636,
    parameter int          Y_MAX       = 476,
    parameter int          SIZE_MIN    = 8,
    parameter int          SPAWN_DELAY = 30,
    parameter int          SPEED_INIT  = 1,
    parameter int          SPEED_MAX   = 7,
    parameter int          WAVE_LEN    = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic      frame_clk,
    input logic      Reset,
    meteor_if.master bus
);
    typedef enum logic {ST_WAIT = 1'b0, ST_FALL = 1'b1} state_t;

    // Parking far off-screen with zero size makes the ball overlap test fail.
    localparam logic [9:0] PARK_POS = 10'd700;

    state_t      state, next_state;
    logic [15:0] wait_cnt, wait_nxt;
    logic [15:0] wave_cnt, wave_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic [9:0]  x_q, x_nxt;
    logic [9:0]  y_q, y_nxt;
    logic [9:0]  size_q, size_nxt;
    logic [2:0]  speed_q, speed_nxt;
    logic [15:0] dodged_q, dodged_nxt;

    logic        wait_done;
    logic        exit_bottom;
    logic [9:0]  spawn_size;
    logic [9:0]  spawn_col;
    logic [9:0]  spawn_x;
    logic [3:0]  speed_inc;

    assign wait_done   = (wait_cnt == 16'(SPAWN_DELAY - 1));
    // 11-bit sum so a large speed near the bottom cannot wrap past Y_MAX.
    assign exit_bottom = ({1'b0, y_q} + {8'b0, speed_q}) > 11'(Y_MAX);

    assign spawn_size = 10'(SIZE_MIN) + {5'b0, lfsr[12:10], 2'b00};
    assign spawn_col  = lfsr[9:0];
    // A column that would push the right edge off-screen is folded back by 512.
    always_comb begin
        spawn_x = spawn_col;
        if (({1'b0, spawn_col} + {1'b0, spawn_size}) > 11'(X_MAX))
            spawn_x = spawn_col - 10'd512;
        else if (spawn_col < 10'(X_MIN))
            spawn_x = 10'(X_MIN);
    end

    assign speed_inc = {1'b0, speed_q} + 4'd1;

    // State and datapath registers.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
            wave_cnt <= '0;
            lfsr     <= LFSR_SEED;
            x_q      <= PARK_POS;
            y_q      <= PARK_POS;
            size_q   <= '0;
            speed_q  <= 3'(SPEED_INIT);
            dodged_q <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_nxt;
            wave_cnt <= wave_nxt;
            lfsr     <= lfsr_nxt;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            size_q   <= size_nxt;
            speed_q  <= speed_nxt;
            dodged_q <= dodged_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_WAIT: if (wait_done) next_state = ST_FALL;
            ST_FALL: if (bus.ball_die || exit_bottom) next_state = ST_WAIT;
            default: next_state = ST_WAIT;
        endcase
    end

    // Datapath next values. ball_die takes priority over the bottom exit.
    always_comb begin
        wait_nxt   = wait_cnt;
        wave_nxt   = wave_cnt;
        x_nxt      = x_q;
        y_nxt      = y_q;
        size_nxt   = size_q;
        speed_nxt  = speed_q;
        dodged_nxt = dodged_q;
        // Galois right shift; the free-running LFSR never reaches zero.
        lfsr_nxt   = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        case (state)
            ST_WAIT: begin
                if (wait_done) begin
                    wait_nxt = '0;
                    x_nxt    = spawn_x;
                    y_nxt    = '0;
                    size_nxt = spawn_size;
                end else begin
                    wait_nxt = wait_cnt + 16'd1;
                end
            end
            ST_FALL: begin
                if (bus.ball_die) begin
                    wait_nxt  = '0;
                    x_nxt     = PARK_POS;
                    y_nxt     = PARK_POS;
                    size_nxt  = '0;
                    speed_nxt = 3'(SPEED_INIT);
                    wave_nxt  = '0;
                end else if (exit_bottom) begin
                    wait_nxt   = '0;
                    x_nxt      = PARK_POS;
                    y_nxt      = PARK_POS;
                    size_nxt   = '0;
                    dodged_nxt = (dodged_q == 16'hFFFF) ? dodged_q : dodged_q + 16'd1;
                    if (wave_cnt == 16'(WAVE_LEN - 1)) begin
                        wave_nxt  = '0;
                        speed_nxt = (speed_inc > 4'(SPEED_MAX)) ? 3'(SPEED_MAX) : speed_inc[2:0];
                    end else begin
                        wave_nxt = wave_cnt + 16'd1;
                    end
                end else begin
                    y_nxt = y_q + {7'b0, speed_q};
                end
            end
            default: ;
        endcase
    end

    assign bus.enemy_x       = x_q;
    assign bus.enemy_y       = y_q;
    assign bus.enemy_size    = size_q;
    assign bus.meteor_active = (state == ST_FALL);
    assign bus.speed         = speed_q;
    assign bus.dodged_count  = dodged_q;
    assign bus.fall_state    = state;
endmodule

// File: tb/tb_meteor_ctrl.sv
module tb_meteor_ctrl;
    logic frame_clk = 1'b0;
    logic Reset;

    always #5 frame_clk = ~frame_clk;

    meteor_if m();
    meteor_if b1();
    meteor_if b2();

    meteor_ctrl dut (.frame_clk(frame_clk), .Reset(Reset), .bus(m));
    // Spawn-clamping instances: SPAWN_DELAY=1 makes the first spawn use the seed.
    meteor_ctrl #(.SPAWN_DELAY(1), .LFSR_SEED(16'h1E76)) dut_fold (
        .frame_clk(frame_clk), .Reset(Reset), .bus(b1));
    meteor_ctrl #(.SPAWN_DELAY(1), .LFSR_SEED(16'h0001)) dut_clamp (
        .frame_clk(frame_clk), .Reset(Reset), .bus(b2));

    int errors = 0;
    int checks = 0;
    int parks_seen = 0;
    int spawns_seen = 0;

    // Park record: {fall frames, last y, dodged_count, speed} after the park edge.
    logic [38:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_park(input int frames, input int last_y, input int dodged, input int spd);
        exp_q.push_back({10'(frames), 10'(last_y), 16'(dodged), 3'(spd)});
    endtask

    task automatic tick;
        @(negedge frame_clk);
        #1;
    endtask

    task automatic wait_parks(input int target, input int budget);
        int n = 0;
        while (parks_seen < target && n < budget) begin
            tick();
            n++;
        end
        if (parks_seen < target) begin
            checks++;
            errors++;
            $display("FAIL park_timeout: got %0d parks expected %0d", parks_seen, target);
        end
    endtask

    task automatic wait_y(input logic [9:0] yv, input int budget);
        int n = 0;
        while (!(m.meteor_active === 1'b1 && m.enemy_y === yv) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL y_timeout: got y=%0d expected y=%0d", m.enemy_y, yv);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x"}, 32'(m.enemy_x), 700);
        check({tag, "_y"}, 32'(m.enemy_y), 700);
        check({tag, "_size"}, 32'(m.enemy_size), 0);
        check({tag, "_speed"}, 32'(m.speed), 1);
        check({tag, "_dodged"}, 32'(m.dodged_count), 0);
        check({tag, "_active"}, 32'(m.meteor_active), 0);
    endtask

    // Monitor: LFSR model plus spawn/park detection on the main instance.
    initial begin
        logic        prev_active;
        logic        after_reset;
        int          fall_frames;
        int          wait_len;
        logic [9:0]  last_y;
        logic [15:0] mdl;
        logic [15:0] l_used;
        logic [9:0]  exp_s;
        logic [9:0]  r;
        logic [9:0]  exp_x;
        logic [38:0] rec;
        prev_active = 1'b0;
        after_reset = 1'b1;
        fall_frames = 0;
        wait_len    = 0;
        last_y      = '0;
        mdl         = 16'hACE1;
        forever begin
            @(negedge frame_clk);
            if (Reset) begin
                mdl         = 16'hACE1;
                prev_active = 1'b0;
                after_reset = 1'b1;
                wait_len    = 0;
                fall_frames = 0;
            end else begin
                l_used = mdl;
                mdl = (mdl >> 1) ^ (mdl[0] ? 16'hB400 : 16'h0000);
                if (m.meteor_active) begin
                    if (!prev_active) begin
                        exp_s = 10'd8 + {5'b0, l_used[12:10], 2'b00};
                        r = l_used[9:0];
                        if ((11'(r) + 11'(exp_s)) > 11'd636) exp_x = r - 10'd512;
                        else if (r < 10'd3) exp_x = 10'd3;
                        else exp_x = r;
                        check("spawn_x", 32'(m.enemy_x), 32'(exp_x));
                        check("spawn_size", 32'(m.enemy_size), 32'(exp_s));
                        check("spawn_y", 32'(m.enemy_y), 0);
                        check("wait_len", wait_len, after_reset ? 29 : 30);
                        after_reset = 1'b0;
                        fall_frames = 0;
                        spawns_seen++;
                    end
                    fall_frames++;
                    last_y = m.enemy_y;
                end else begin
                    if (prev_active) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_park: got park %0d expected none", parks_seen + 1);
                        end else begin
                            rec = exp_q.pop_front();
                            check("fall_frames", fall_frames, 32'(rec[38:29]));
                            check("last_y", 32'(last_y), 32'(rec[28:19]));
                            check("dodged", 32'(m.dodged_count), 32'(rec[18:3]));
                            check("speed", 32'(m.speed), 32'(rec[2:0]));
                            check("park_x", 32'(m.enemy_x), 700);
                            check("park_y", 32'(m.enemy_y), 700);
                            check("park_size", 32'(m.enemy_size), 0);
                        end
                        parks_seen++;
                        wait_len = 0;
                    end
                    wait_len++;
                end
                prev_active = m.meteor_active;
            end
        end
    end

    // Stimulus.
    initial begin
        int vf;
        int va;
        int sp0;
        Reset = 1'b1;
        m.ball_die = 1'b0;
        b1.ball_die = 1'b0;
        b2.ball_die = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        Reset = 1'b0;

        // First edge after release spawns from the seed on the clamp instances.
        tick();
        check("fold_x", 32'(b1.enemy_x), 118);
        check("fold_size", 32'(b1.enemy_size), 36);
        check("fold_active", 32'(b1.meteor_active), 1);
        check("clamp_x", 32'(b2.enemy_x), 3);
        check("clamp_size", 32'(b2.enemy_size), 8);
        check("clamp_y", 32'(b2.enemy_y), 0);

        // 64 untouched dodges: speed ramps 1..7 and saturates.
        for (int k = 1; k <= 64; k++) begin
            vf = ((k - 1) / 8 + 1 > 7) ? 7 : (k - 1) / 8 + 1;
            va = (k / 8 + 1 > 7) ? 7 : k / 8 + 1;
            push_park(476 / vf + 1, (476 / vf) * vf, k, va);
        end
        wait_parks(64, 20000);

        // Collision on the exit frame at speed 7 (y=476): no dodge credited.
        push_park(69, 476, 64, 1);
        wait_y(10'd476, 300);
        m.ball_die = 1'b1;
        tick();
        m.ball_die = 1'b0;
        wait_parks(65, 10);

        // ball_die during WAIT must not disturb the 30-frame wait.
        for (int i = 0; i < 10; i++) tick();
        m.ball_die = 1'b1;
        tick();
        m.ball_die = 1'b0;

        // Ramp back to speed 3, then three dodges at speed 3 (wave counter 3).
        for (int j = 1; j <= 16; j++) begin
            push_park(476 / ((j - 1) / 8 + 1) + 1, (476 / ((j - 1) / 8 + 1)) * ((j - 1) / 8 + 1),
                      64 + j, j / 8 + 1);
        end
        for (int j = 1; j <= 3; j++) push_park(159, 474, 80 + j, 3);
        wait_parks(84, 10000);

        // Hit mid-fall at y=150, speed 3.
        sp0 = parks_seen;
        push_park(51, 150, 83, 1);
        wait_y(10'd150, 300);
        m.ball_die = 1'b1;
        tick();
        m.ball_die = 1'b0;
        wait_parks(sp0 + 1, 10);

        // Wave counter was cleared: speed steps to 2 only on the 8th dodge.
        for (int j = 1; j <= 8; j++) push_park(477, 476, 83 + j, (j == 8) ? 2 : 1);
        wait_parks(93, 6000);

        // Reset in the middle of a fall.
        wait_y(10'd100, 400);
        Reset = 1'b1;
        tick();
        check_reset_values("midreset");
        Reset = 1'b0;
        sp0 = spawns_seen;
        for (int n = 0; n < 100 && spawns_seen == sp0; n++) tick();
        check("respawn_after_reset", spawns_seen, sp0 + 1);

        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
